lcd_pattern_sequencer: RTL and testbench

- Parametrised colour-ramp and test-pattern generator that issues rectangular fill requests to the ST7735 display controller over its WRITE_EN / IS_BUSY handshake.
- Sequences blue, green and red ramps over the full screen, then a grey ramp inside a configurable window, and repeats.
- Adds channel-width parameters, a programmable ramp step, hold/enable control, a busy-acknowledge timeout, and a fully synchronous handshake.
- Sits between the board top level and the ST7735 instance; replaces the ad-hoc colour logic in the top level.

---
 rtl/lcd_pattern_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_lcd_pattern_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_sequencer.sv
// Colour-ramp / grey-window test-pattern generator that issues rectangular fill
// requests to an ST7735 controller over the WRITE_EN / IS_BUSY handshake.
module lcd_pattern_sequencer #(
   parameter int WIDTH        = 160,
   parameter int HEIGHT       = 120,
   parameter int RED_BITS     = 5,
   parameter int GREEN_BITS   = 6,
   parameter int BLUE_BITS    = 5,
   parameter int STEP         = 1,
   parameter int SQ_X0        = 100,
   parameter int SQ_Y0        = 50,
   parameter int SQ_X1        = 150,
   parameter int SQ_Y1        = 100,
   parameter int BUSY_TIMEOUT = 1024,
   localparam int PIX_W       = RED_BITS + GREEN_BITS + BLUE_BITS
) (
   input  logic             SYSTEM_CLK,
   input  logic             RESET_N,
   input  logic             ENABLE,
   input  logic             HOLD,
   input  logic             LCD_READY,
   input  logic             IS_BUSY,
   output logic             WRITE_EN,
   output logic [PIX_W-1:0] COLOR_PIXEL,
   output logic [15:0]      COLOR_X,
   output logic [15:0]      COLOR_Y,
   output logic [15:0]      COLOR_X_END,
   output logic [15:0]      COLOR_Y_END,
   output logic [1:0]       PHASE,
   output logic             CYCLE_DONE,
   output logic             TIMEOUT_ERR
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   localparam logic [RED_BITS-1:0]   RED_MAX   = '1;
   localparam logic [GREEN_BITS-1:0] GREEN_MAX = '1;
   localparam logic [BLUE_BITS-1:0]  BLUE_MAX  = '1;

   localparam logic [15:0] FULL_X1 = 16'(WIDTH - 1);
   localparam logic [15:0] FULL_Y1 = 16'(HEIGHT - 1);
   localparam logic [15:0] SQ_XA   = 16'(SQ_X0);
   localparam logic [15:0] SQ_YA   = 16'(SQ_Y0);
   localparam logic [15:0] SQ_XB   = 16'(SQ_X1);
   localparam logic [15:0] SQ_YB   = 16'(SQ_Y1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, ADVANCE} state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   busy_q;
   logic                   start_q;
   logic [CNT_W-1:0]       req_count;
   logic                   timeout_err;
   logic                   timeout_hit;

   logic [RED_BITS-1:0]    red;
   logic [GREEN_BITS-1:0]  green;
   logic [BLUE_BITS-1:0]   blue;
   logic [1:0]             phase;
   logic [15:0]            win_x0;
   logic [15:0]            win_y0;
   logic [15:0]            win_x1;
   logic [15:0]            win_y1;

   logic                   red_over;
   logic                   green_over;
   logic                   blue_over;
   logic [RED_BITS-1:0]    red_step;
   logic [GREEN_BITS-1:0]  green_step;
   logic [BLUE_BITS-1:0]   blue_step;
   logic                   all_ones;
   logic                   do_advance;

   // Overflow is judged on the un-truncated sum so the max-or-last value is
   // always sent and an overshooting value never is.
   always_comb begin
      red_over    = (32'(red)   + 32'(STEP)) > 32'(RED_MAX);
      green_over  = (32'(green) + 32'(STEP)) > 32'(GREEN_MAX);
      blue_over   = (32'(blue)  + 32'(STEP)) > 32'(BLUE_MAX);
      red_step    = red   + RED_BITS'(STEP);
      green_step  = green + GREEN_BITS'(STEP);
      blue_step   = blue  + BLUE_BITS'(STEP);
      all_ones    = (red == RED_MAX) && (green == GREEN_MAX) && (blue == BLUE_MAX);
      timeout_hit = (req_count == CNT_LAST);
      do_advance  = (state == ADVANCE) && !HOLD;
   end

   // The start request is registered once, so IDLE leaves one edge after sampling.
   always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         req_count   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state     <= next_state;
         busy_q    <= IS_BUSY;
         start_q   <= ENABLE && LCD_READY;
         req_count <= (state == REQ) ? req_count + 1'b1 : '0;
         if ((state == REQ) && !IS_BUSY && timeout_hit)
            timeout_err <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (start_q) next_state = REQ;
         REQ: begin
            if (IS_BUSY)          next_state = WAIT_DONE;
            else if (timeout_hit) next_state = IDLE;
         end
         WAIT_DONE: if (busy_q && !IS_BUSY) next_state = ADVANCE;
         ADVANCE:   next_state = (ENABLE && LCD_READY) ? REQ : IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Colour, window and phase only move on the edge that leaves ADVANCE.
   always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         red    <= '0;
         green  <= '0;
         blue   <= '0;
         phase  <= 2'd0;
         win_x0 <= 16'd0;
         win_y0 <= 16'd0;
         win_x1 <= FULL_X1;
         win_y1 <= FULL_Y1;
      end else if (do_advance) begin
         case (phase)
            2'd0: begin
               if (blue_over) begin
                  blue  <= '0;
                  phase <= 2'd1;
               end else begin
                  blue <= blue_step;
               end
            end
            2'd1: begin
               if (green_over) begin
                  green <= '0;
                  phase <= 2'd2;
               end else begin
                  green <= green_step;
               end
            end
            2'd2: begin
               if (red_over) begin
                  red    <= '0;
                  green  <= '0;
                  blue   <= '0;
                  phase  <= 2'd3;
                  win_x0 <= SQ_XA;
                  win_y0 <= SQ_YA;
                  win_x1 <= SQ_XB;
                  win_y1 <= SQ_YB;
               end else begin
                  red <= red_step;
               end
            end
            default: begin
               if (all_ones) begin
                  red    <= '0;
                  green  <= '0;
                  blue   <= '0;
                  phase  <= 2'd0;
                  win_x0 <= 16'd0;
                  win_y0 <= 16'd0;
                  win_x1 <= FULL_X1;
                  win_y1 <= FULL_Y1;
               end else begin
                  red   <= red_over   ? RED_MAX   : red_step;
                  green <= green_over ? GREEN_MAX : green_step;
                  blue  <= blue_over  ? BLUE_MAX  : blue_step;
               end
            end
         endcase
      end
   end

   always_comb begin
      WRITE_EN    = (state == REQ);
      CYCLE_DONE  = do_advance && (phase == 2'd3) && all_ones;
      COLOR_PIXEL = {red, green, blue};
      COLOR_X     = win_x0;
      COLOR_Y     = win_y0;
      COLOR_X_END = win_x1;
      COLOR_Y_END = win_y1;
      PHASE       = phase;
      TIMEOUT_ERR = timeout_err;
   end

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
// Randomised handshake bench for lcd_pattern_sequencer; expected fills come from
// a list of colours/windows built up front from the ramp rules.
module tb_lcd_pattern_sequencer;

   localparam int TB_STEP    = 1;
   localparam int TB_TIMEOUT = 16;
   localparam int R_BITS     = 5;
   localparam int G_BITS     = 6;
   localparam int B_BITS     = 5;
   localparam int PW         = R_BITS + G_BITS + B_BITS;

   logic          sys_clk;
   logic          reset_n;
   logic          enable;
   logic          hold;
   logic          lcd_ready;
   logic          is_busy;
   logic          write_en;
   logic [PW-1:0] color_pixel;
   logic [15:0]   color_x;
   logic [15:0]   color_y;
   logic [15:0]   color_x_end;
   logic [15:0]   color_y_end;
   logic [1:0]    phase;
   logic          cycle_done;
   logic          timeout_err;

   int compared   = 0;
   int mismatched = 0;

   logic [PW-1:0] exp_pix[$];
   logic [63:0]   exp_win[$];
   logic [1:0]    exp_phase[$];
   int            idx = 0;
   bit            wrapped = 0;

   lcd_pattern_sequencer #(
      .WIDTH(160), .HEIGHT(120),
      .RED_BITS(R_BITS), .GREEN_BITS(G_BITS), .BLUE_BITS(B_BITS),
      .STEP(TB_STEP),
      .SQ_X0(100), .SQ_Y0(50), .SQ_X1(150), .SQ_Y1(100),
      .BUSY_TIMEOUT(TB_TIMEOUT)
   ) dut (
      .SYSTEM_CLK (sys_clk),
      .RESET_N    (reset_n),
      .ENABLE     (enable),
      .HOLD       (hold),
      .LCD_READY  (lcd_ready),
      .IS_BUSY    (is_busy),
      .WRITE_EN   (write_en),
      .COLOR_PIXEL(color_pixel),
      .COLOR_X    (color_x),
      .COLOR_Y    (color_y),
      .COLOR_X_END(color_x_end),
      .COLOR_Y_END(color_y_end),
      .PHASE      (phase),
      .CYCLE_DONE (cycle_done),
      .TIMEOUT_ERR(timeout_err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic logic [PW-1:0] pixOf(input int r, input int g, input int b);
      return PW'((r << (G_BITS + B_BITS)) | (g << B_BITS) | b);
   endfunction

   task automatic addFill(input logic [PW-1:0] p, input logic [63:0] w, input logic [1:0] ph);
      exp_pix.push_back(p);
      exp_win.push_back(w);
      exp_phase.push_back(ph);
   endtask

   task automatic buildModel();
      int rm = (1 << R_BITS) - 1;
      int gm = (1 << G_BITS) - 1;
      int bm = (1 << B_BITS) - 1;
      logic [63:0] full = {16'd0, 16'd0, 16'd159, 16'd119};
      logic [63:0] sq   = {16'd100, 16'd50, 16'd150, 16'd100};
      int r = 0;
      int g = 0;
      int b = 0;
      bit done = 0;
      for (int v = 0; v <= bm; v += TB_STEP) addFill(pixOf(0, 0, v), full, 2'd0);
      for (int v = 0; v <= gm; v += TB_STEP) addFill(pixOf(0, v, 0), full, 2'd1);
      for (int v = 0; v <= rm; v += TB_STEP) addFill(pixOf(v, 0, 0), full, 2'd2);
      while (!done) begin
         addFill(pixOf(r, g, b), sq, 2'd3);
         if (r == rm && g == gm && b == bm) begin
            done = 1;
         end else begin
            r = (r + TB_STEP > rm) ? rm : r + TB_STEP;
            g = (g + TB_STEP > gm) ? gm : g + TB_STEP;
            b = (b + TB_STEP > bm) ? bm : b + TB_STEP;
         end
      end
   endtask

   task automatic checkFill(input string tag);
      checkOutput({tag, "_pixel"}, 64'(color_pixel), 64'(exp_pix[idx]));
      checkOutput({tag, "_window"}, {color_x, color_y, color_x_end, color_y_end}, exp_win[idx]);
      checkOutput({tag, "_phase"}, 64'(phase), 64'(exp_phase[idx]));
   endtask

   task automatic waitRequest();
      int n = 0;
      while (write_en !== 1'b1 && n < 60) begin
         @(posedge sys_clk); #1;
         n++;
      end
      checkOutput("req_wait", 64'(write_en), 64'd1);
   endtask

   // One complete fill; drop_sel 1 drops ENABLE, 2 drops LCD_READY during busy.
   task automatic applyStimulus(input bit hold_val, input int drop_sel);
      int  d;
      int  busy_len;
      bit  last;
      waitRequest();
      checkFill("fill");
      d = $urandom_range(0, 3);
      repeat (d) begin
         @(posedge sys_clk); #1;
         checkOutput("req_hold", 64'(write_en), 64'd1);
      end
      is_busy = 1'b1;
      hold    = hold_val;
      if (drop_sel == 1) enable = 1'b0;
      if (drop_sel == 2) lcd_ready = 1'b0;
      @(posedge sys_clk); #1;
      checkOutput("req_drop", 64'(write_en), 64'd0);
      busy_len = $urandom_range(0, 4);
      repeat (busy_len) begin
         @(posedge sys_clk); #1;
         checkOutput("busy_wr", 64'(write_en), 64'd0);
         checkOutput("busy_pixel", 64'(color_pixel), 64'(exp_pix[idx]));
      end
      is_busy = 1'b0;
      last = (idx == exp_pix.size() - 1);
      @(posedge sys_clk); #1;
      checkOutput("adv_wr", 64'(write_en), 64'd0);
      checkOutput("cycle_done", 64'(cycle_done), 64'(last && !hold_val));
      @(posedge sys_clk); #1;
      checkOutput("next_req", 64'(write_en), 64'(drop_sel == 0));
      checkOutput("done_low", 64'(cycle_done), 64'd0);
      hold = 1'b0;
      if (!hold_val) begin
         if (last) wrapped = 1;
         idx = last ? 0 : idx + 1;
      end
   endtask

   task automatic reEnable();
      int k = $urandom_range(1, 5);
      repeat (k) begin
         @(posedge sys_clk); #1;
         checkOutput("parked", 64'(write_en), 64'd0);
      end
      checkFill("parked");
      enable    = 1'b1;
      lcd_ready = 1'b1;
      @(posedge sys_clk); #1;
      checkOutput("en_lat0", 64'(write_en), 64'd0);
      @(posedge sys_clk); #1;
      checkOutput("en_lat1", 64'(write_en), 64'd1);
   endtask

   initial begin
      int highs;
      int guard;
      int drop_sel;
      int red_mid;
      buildModel();
      reset_n   = 1'b0;
      enable    = 1'b0;
      hold      = 1'b0;
      lcd_ready = 1'b1;
      is_busy   = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("rst_wr", 64'(write_en), 64'd0);
      checkOutput("rst_pixel", 64'(color_pixel), 64'd0);
      checkOutput("rst_phase", 64'(phase), 64'd0);
      checkOutput("rst_done", 64'(cycle_done), 64'd0);
      checkOutput("rst_terr", 64'(timeout_err), 64'd0);
      checkOutput("rst_window", {color_x, color_y, color_x_end, color_y_end},
                  {16'd0, 16'd0, 16'd159, 16'd119});
      @(negedge sys_clk);
      reset_n = 1'b1;
      @(posedge sys_clk); #1;

      $display("[TB] start latency and busy timeout");
      enable = 1'b1;
      @(posedge sys_clk); #1;
      checkOutput("lat0", 64'(write_en), 64'd0);
      @(posedge sys_clk); #1;
      checkOutput("lat1", 64'(write_en), 64'd1);
      highs = 1;
      while (write_en === 1'b1 && highs < 100) begin
         @(posedge sys_clk); #1;
         if (write_en === 1'b1) highs++;
      end
      checkOutput("timeout_len", 64'(highs), 64'(TB_TIMEOUT));
      checkOutput("timeout_err", 64'(timeout_err), 64'd1);
      @(posedge sys_clk); #1;
      checkOutput("retry", 64'(write_en), 64'd1);

      $display("[TB] full sequence with random hold and enable drops");
      guard = 0;
      while (!(wrapped && idx >= 3) && guard < 500) begin
         drop_sel = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 2) : 0;
         applyStimulus($urandom_range(0, 7) == 0, drop_sel);
         if (drop_sel != 0) reEnable();
         guard++;
      end
      checkOutput("wrapped", 64'(wrapped), 64'd1);
      checkOutput("terr_sticky", 64'(timeout_err), 64'd1);

      $display("[TB] hold for three fills");
      repeat (3) applyStimulus(1'b1, 0);
      applyStimulus(1'b0, 0);

      $display("[TB] async reset in red phase");
      red_mid = (1 << B_BITS) / TB_STEP + (1 << G_BITS) / TB_STEP + 5;
      guard = 0;
      while (idx != red_mid && guard < 500) begin
         applyStimulus($urandom_range(0, 9) == 0, 0);
         guard++;
      end
      checkOutput("red_phase", 64'(phase), 64'd2);
      waitRequest();
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_wr", 64'(write_en), 64'd0);
      checkOutput("arst_phase", 64'(phase), 64'd0);
      checkOutput("arst_pixel", 64'(color_pixel), 64'd0);
      checkOutput("arst_terr", 64'(timeout_err), 64'd0);
      checkOutput("arst_window", {color_x, color_y, color_x_end, color_y_end},
                  {16'd0, 16'd0, 16'd159, 16'd119});
      idx = 0;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      reset_n = 1'b1;
      @(posedge sys_clk); #1;
      checkOutput("rel_lat0", 64'(write_en), 64'd0);
      @(posedge sys_clk); #1;
      checkOutput("rel_lat1", 64'(write_en), 64'd1);
      repeat (4) applyStimulus(1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
